// File: rtl/rename_pkg.sv
// Shared rename types and helpers: physical/architectural register types,
// default free-list geometry and the lane prefix-count used by compaction.
package rename_pkg;

    localparam int FL_ARCH_REGS = 64;
    localparam int FL_PHYS_REGS = 128;
    localparam int FL_DEPTH     = FL_PHYS_REGS - FL_ARCH_REGS;
    localparam int FL_PRF_W     = $clog2(FL_PHYS_REGS);
    localparam int FL_ARF_W     = $clog2(FL_ARCH_REGS);

    typedef logic [FL_PRF_W-1:0] phys_reg_t;
    typedef logic [FL_ARF_W-1:0] arch_reg_t;

    // Number of set bits in mask[upto-1:0]; upto=0 yields 0.
    function automatic int lane_prefix(input logic [31:0] mask, input int upto);
        int cnt;
        cnt = 0;
        for (int j = 0; j < 32; j++) begin
            if (j < upto && mask[j]) begin
                cnt++;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fl_compact.sv
// Prefix-popcount lane compaction: each active lane gets its rank among the
// active lanes below it, plus the total active count.
module fl_compact
    import rename_pkg::*;
#(
    parameter int LANES = 2,
    parameter int CW    = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]         i_mask,
    output logic [LANES-1:0][CW-1:0] o_offset,
    output logic [CW-1:0]            o_count
);

    logic [31:0] w_mask_ext;

    assign w_mask_ext = 32'(i_mask);

    always_comb begin
        o_offset = '0;
        for (int i = 0; i < LANES; i++) begin
            o_offset[i] = CW'(lane_prefix(w_mask_ext, i));
        end
        o_count = CW'(lane_prefix(w_mask_ext, LANES));
    end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical registers for rename: dispatch pops at head,
// commit pushes Told at tail, flush rewinds head to the committed retire head.
module free_list
    import rename_pkg::*;
#(
    parameter int DISPATCH_WIDTH = 2,
    parameter int COMMIT_WIDTH   = 2,
    parameter int ARCH_REGS      = FL_ARCH_REGS,
    parameter int PHYS_REGS      = FL_PHYS_REGS,
    localparam int DEPTH         = PHYS_REGS - ARCH_REGS,
    localparam int PW            = $clog2(PHYS_REGS),
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DISPATCH_WIDTH-1:0]          alloc_req_i,
    output logic                               alloc_ready_o,
    output logic [DISPATCH_WIDTH-1:0]          alloc_gnt_o,
    output logic [DISPATCH_WIDTH-1:0][PW-1:0]  alloc_prf_o,
    input  logic [COMMIT_WIDTH-1:0]            commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0]            commit_rd_wen_i,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0]    commit_old_prf_i,
    input  logic                               flush_i,
    output logic [AW:0]                        free_count_o
);

    localparam int DCW = $clog2(DISPATCH_WIDTH + 1);
    localparam int CCW = $clog2(COMMIT_WIDTH + 1);

    logic [PW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_retire_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_spec_cnt;
    logic [AW:0]   r_ret_cnt;

    logic [DISPATCH_WIDTH-1:0][DCW-1:0] w_req_off;
    logic [DCW-1:0]                     w_req_cnt;
    logic [COMMIT_WIDTH-1:0]            w_rel_mask;
    logic [COMMIT_WIDTH-1:0][CCW-1:0]   w_rel_off;
    logic [CCW-1:0]                     w_rel_cnt;
    logic [CCW-1:0]                     w_retire_cnt;
    logic                               w_alloc_ok;
    logic [DCW-1:0]                     w_alloc_cnt;
    logic [AW+1:0]                      w_spec_cnt_wide;
    logic [AW:0]                        w_spec_cnt_nxt;
    logic [AW:0]                        w_ret_cnt_nxt;
    logic [AW-1:0]                      w_retire_head_nxt;

    assign w_rel_mask = commit_valid_i & commit_rd_wen_i;

    fl_compact #(.LANES(DISPATCH_WIDTH), .CW(DCW)) u_alloc_compact (
        .i_mask   (alloc_req_i),
        .o_offset (w_req_off),
        .o_count  (w_req_cnt)
    );

    fl_compact #(.LANES(COMMIT_WIDTH), .CW(CCW)) u_rel_compact (
        .i_mask   (w_rel_mask),
        .o_offset (w_rel_off),
        .o_count  (w_rel_cnt)
    );

    // Grants are all-or-nothing, so the request compaction doubles as the grant one.
    assign alloc_ready_o = (r_spec_cnt >= (AW+1)'(DISPATCH_WIDTH));
    assign w_alloc_ok    = alloc_ready_o && !flush_i;
    assign alloc_gnt_o   = w_alloc_ok ? alloc_req_i : '0;
    assign w_alloc_cnt   = w_alloc_ok ? w_req_cnt : '0;
    assign free_count_o  = r_spec_cnt;

    always_comb begin
        alloc_prf_o = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            alloc_prf_o[i] = r_mem[r_head + AW'(w_req_off[i])];
        end
    end

    // A retiring writer both returns its Told and consumes its own allocation.
    assign w_retire_cnt      = w_rel_cnt;
    assign w_retire_head_nxt = r_retire_head + AW'(w_retire_cnt);
    assign w_ret_cnt_nxt     = r_ret_cnt + (AW+1)'(w_rel_cnt) - (AW+1)'(w_retire_cnt);
    assign w_spec_cnt_wide   = (AW+2)'(r_spec_cnt) - (AW+2)'(w_alloc_cnt) + (AW+2)'(w_rel_cnt);
    assign w_spec_cnt_nxt    = w_spec_cnt_wide[AW:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= PW'(ARCH_REGS + i);
            end
            r_head        <= '0;
            r_retire_head <= '0;
            r_tail        <= '0;
            r_spec_cnt    <= (AW+1)'(DEPTH);
            r_ret_cnt     <= (AW+1)'(DEPTH);
        end else begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (w_rel_mask[i]) begin
                    r_mem[r_tail + AW'(w_rel_off[i])] <= commit_old_prf_i[i];
                end
            end
            r_tail        <= r_tail + AW'(w_rel_cnt);
            r_retire_head <= w_retire_head_nxt;
            r_ret_cnt     <= w_ret_cnt_nxt;
            if (flush_i) begin
                r_head     <= w_retire_head_nxt;
                r_spec_cnt <= w_ret_cnt_nxt;
            end else begin
                r_head     <= r_head + AW'(w_alloc_cnt);
                r_spec_cnt <= w_spec_cnt_nxt;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (w_spec_cnt_wide <= (AW+2)'(DEPTH)));

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset, lane ordering, low-water stall,
// flush rewind, flush with commit, and a long wrap run against a free-list model.
module tb_free_list;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      alloc_req_i;
    logic            alloc_ready_o;
    logic [1:0]      alloc_gnt_o;
    logic [1:0][6:0] alloc_prf_o;
    logic [1:0]      commit_valid_i;
    logic [1:0]      commit_rd_wen_i;
    logic [1:0][6:0] commit_old_prf_i;
    logic            flush_i;
    logic [6:0]      free_count_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    free_list dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_req_i      (alloc_req_i),
        .alloc_ready_o    (alloc_ready_o),
        .alloc_gnt_o      (alloc_gnt_o),
        .alloc_prf_o      (alloc_prf_o),
        .commit_valid_i   (commit_valid_i),
        .commit_rd_wen_i  (commit_rd_wen_i),
        .commit_old_prf_i (commit_old_prf_i),
        .flush_i          (flush_i),
        .free_count_o     (free_count_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req_i      = '0;
        commit_valid_i   = '0;
        commit_rd_wen_i  = '0;
        commit_old_prf_i = '0;
        flush_i          = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (alloc_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0b exp 1", alloc_ready_o); end
        n_vec++; if (alloc_gnt_o !== 2'b00) begin n_err++; $display("FAIL rst_gnt got %b exp 00", alloc_gnt_o); end
        n_vec++; if (free_count_o !== 7'd64) begin n_err++; $display("FAIL rst_count got %0d exp 64", free_count_o); end
        alloc_req_i = 2'b11;
        step();
        // reset asserted together with flush, alloc and commit must win
        rst = 1'b1; flush_i = 1'b1;
        commit_valid_i = 2'b01; commit_rd_wen_i = 2'b01; commit_old_prf_i[0] = 7'd3;
        step();
        rst = 1'b0; idle(); #1;
        n_vec++; if (free_count_o !== 7'd64) begin n_err++; $display("FAIL midrst_count got %0d exp 64", free_count_o); end
        alloc_req_i = 2'b11; #1;
        n_vec++; if (alloc_prf_o[0] !== 7'd64) begin n_err++; $display("FAIL midrst_prf0 got %0d exp 64", alloc_prf_o[0]); end
        n_vec++; if (alloc_prf_o[1] !== 7'd65) begin n_err++; $display("FAIL midrst_prf1 got %0d exp 65", alloc_prf_o[1]); end
        idle();
    endtask

    task automatic test_dual_alloc();
        do_reset();
        alloc_req_i = 2'b11; #1;
        n_vec++; if (alloc_prf_o[0] !== 7'd64) begin n_err++; $display("FAIL dual_prf0 got %0d exp 64", alloc_prf_o[0]); end
        n_vec++; if (alloc_prf_o[1] !== 7'd65) begin n_err++; $display("FAIL dual_prf1 got %0d exp 65", alloc_prf_o[1]); end
        n_vec++; if (alloc_gnt_o !== 2'b11) begin n_err++; $display("FAIL dual_gnt got %b exp 11", alloc_gnt_o); end
        step();
        alloc_req_i = 2'b00; #1;
        n_vec++; if (free_count_o !== 7'd62) begin n_err++; $display("FAIL dual_count got %0d exp 62", free_count_o); end
        alloc_req_i = 2'b01; #1;
        n_vec++; if (alloc_prf_o[0] !== 7'd66) begin n_err++; $display("FAIL dual_head2 got %0d exp 66", alloc_prf_o[0]); end
        idle();
    endtask

    task automatic test_single_lane();
        do_reset();
        alloc_req_i = 2'b10; #1;
        n_vec++; if (alloc_prf_o[1] !== 7'd64) begin n_err++; $display("FAIL lane1_prf got %0d exp 64", alloc_prf_o[1]); end
        n_vec++; if (alloc_gnt_o !== 2'b10) begin n_err++; $display("FAIL lane1_gnt got %b exp 10", alloc_gnt_o); end
        step();
        alloc_req_i = 2'b01; #1;
        n_vec++; if (free_count_o !== 7'd63) begin n_err++; $display("FAIL lane1_count got %0d exp 63", free_count_o); end
        n_vec++; if (alloc_prf_o[0] !== 7'd65) begin n_err++; $display("FAIL lane1_next got %0d exp 65", alloc_prf_o[0]); end
        idle();
    endtask

    task automatic test_drain();
        do_reset();
        alloc_req_i = 2'b10;
        step();
        alloc_req_i = 2'b11;
        repeat (31) step();
        alloc_req_i = 2'b00; #1;
        n_vec++; if (free_count_o !== 7'd1) begin n_err++; $display("FAIL drain_count got %0d exp 1", free_count_o); end
        n_vec++; if (alloc_ready_o !== 1'b0) begin n_err++; $display("FAIL drain_ready got %0b exp 0", alloc_ready_o); end
        alloc_req_i = 2'b11; #1;
        n_vec++; if (alloc_gnt_o !== 2'b00) begin n_err++; $display("FAIL drain_gnt got %b exp 00", alloc_gnt_o); end
        step();
        alloc_req_i = 2'b00; #1;
        n_vec++; if (free_count_o !== 7'd1) begin n_err++; $display("FAIL drain_hold got %0d exp 1", free_count_o); end
        commit_valid_i = 2'b01; commit_rd_wen_i = 2'b01; commit_old_prf_i[0] = 7'd5;
        step();
        idle(); #1;
        n_vec++; if (free_count_o !== 7'd2) begin n_err++; $display("FAIL refill_count got %0d exp 2", free_count_o); end
        n_vec++; if (alloc_ready_o !== 1'b1) begin n_err++; $display("FAIL refill_ready got %0b exp 1", alloc_ready_o); end
        // head sits at the last slot, the returned PRF landed in slot 0
        alloc_req_i = 2'b11; #1;
        n_vec++; if (alloc_prf_o[0] !== 7'd127) begin n_err++; $display("FAIL wrap_prf0 got %0d exp 127", alloc_prf_o[0]); end
        n_vec++; if (alloc_prf_o[1] !== 7'd5) begin n_err++; $display("FAIL wrap_prf1 got %0d exp 5", alloc_prf_o[1]); end
        step();
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        alloc_req_i = 2'b11;
        step();
        step();
        idle();
        commit_valid_i = 2'b01; commit_rd_wen_i = 2'b01; commit_old_prf_i[0] = 7'd3;
        step();
        idle(); #1;
        n_vec++; if (free_count_o !== 7'd61) begin n_err++; $display("FAIL preflush_count got %0d exp 61", free_count_o); end
        flush_i = 1'b1;
        step();
        idle(); #1;
        n_vec++; if (free_count_o !== 7'd64) begin n_err++; $display("FAIL flush_count got %0d exp 64", free_count_o); end
        alloc_req_i = 2'b11; #1;
        n_vec++; if (alloc_prf_o[0] !== 7'd65) begin n_err++; $display("FAIL flush_prf0 got %0d exp 65", alloc_prf_o[0]); end
        n_vec++; if (alloc_prf_o[1] !== 7'd66) begin n_err++; $display("FAIL flush_prf1 got %0d exp 66", alloc_prf_o[1]); end
        idle();
    endtask

    task automatic test_flush_commit();
        do_reset();
        alloc_req_i = 2'b11;
        step();
        flush_i = 1'b1;
        commit_valid_i = 2'b01; commit_rd_wen_i = 2'b01; commit_old_prf_i[0] = 7'd9;
        #1;
        n_vec++; if (alloc_gnt_o !== 2'b00) begin n_err++; $display("FAIL fc_gnt got %b exp 00", alloc_gnt_o); end
        step();
        idle(); #1;
        n_vec++; if (free_count_o !== 7'd64) begin n_err++; $display("FAIL fc_count got %0d exp 64", free_count_o); end
        alloc_req_i = 2'b11; #1;
        n_vec++; if (alloc_prf_o[0] !== 7'd65) begin n_err++; $display("FAIL fc_prf0 got %0d exp 65", alloc_prf_o[0]); end
        n_vec++; if (alloc_prf_o[1] !== 7'd66) begin n_err++; $display("FAIL fc_prf1 got %0d exp 66", alloc_prf_o[1]); end
        repeat (31) step();
        alloc_req_i = 2'b00; #1;
        n_vec++; if (free_count_o !== 7'd2) begin n_err++; $display("FAIL fc_low got %0d exp 2", free_count_o); end
        alloc_req_i = 2'b11; #1;
        n_vec++; if (alloc_prf_o[0] !== 7'd127) begin n_err++; $display("FAIL fc_tail0 got %0d exp 127", alloc_prf_o[0]); end
        n_vec++; if (alloc_prf_o[1] !== 7'd9) begin n_err++; $display("FAIL fc_tail1 got %0d exp 9", alloc_prf_o[1]); end
        step();
        idle();
    endtask

    task automatic test_wrap();
        logic [6:0]   exp_q[$];
        logic [6:0]   rat[64];
        logic [1:0]   req;
        logic [6:0]   got;
        logic [127:0] seen;
        logic         dup;
        int           k;
        int           rd;
        do_reset();
        exp_q = {};
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(7'(64 + i));
            rat[i] = 7'(i);
        end
        for (int it = 0; it < 200; it++) begin
            case (it % 4)
                0:       req = 2'b11;
                1:       req = 2'b01;
                2:       req = 2'b10;
                default: req = 2'b11;
            endcase
            alloc_req_i      = req;
            commit_valid_i   = req;
            commit_rd_wen_i  = req;
            commit_old_prf_i = '0;
            if (req == 2'b01) begin
                // valid commit without a destination must not return anything
                commit_valid_i[1]   = 1'b1;
                commit_old_prf_i[1] = 7'h7f;
            end
            #1;
            n_vec++; if (alloc_gnt_o !== req) begin n_err++; $display("FAIL wrap_gnt it=%0d got %b exp %b", it, alloc_gnt_o, req); end
            k = 0;
            for (int j = 0; j < 2; j++) begin
                if (req[j]) begin
                    got = alloc_prf_o[j];
                    n_vec++; if (got !== exp_q[k]) begin n_err++; $display("FAIL wrap_prf it=%0d lane=%0d got %0d exp %0d", it, j, got, exp_q[k]); end
                    dup = 1'b0;
                    for (int r = 0; r < 64; r++) begin
                        if (rat[r] == got) dup = 1'b1;
                    end
                    n_vec++; if (dup !== 1'b0) begin n_err++; $display("FAIL wrap_live it=%0d lane=%0d got %0d exp unmapped", it, j, got); end
                    rd = (it * 2 + j) % 64;
                    commit_old_prf_i[j] = rat[rd];
                    rat[rd] = got;
                    k++;
                end
            end
            repeat (k) void'(exp_q.pop_front());
            for (int j = 0; j < 2; j++) begin
                if (req[j]) exp_q.push_back(commit_old_prf_i[j]);
            end
            step();
            idle(); #1;
            n_vec++; if (32'(free_count_o) !== exp_q.size()) begin n_err++; $display("FAIL wrap_count it=%0d got %0d exp %0d", it, free_count_o, exp_q.size()); end
        end
        seen = '0;
        foreach (exp_q[i]) seen[exp_q[i]] = 1'b1;
        for (int r = 0; r < 64; r++) seen[rat[r]] = 1'b1;
        n_vec++; if (seen !== {128{1'b1}}) begin n_err++; $display("FAIL wrap_set got %h exp all ones", seen); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_dual_alloc();
        test_single_lane();
        test_drain();
        test_flush();
        test_flush_commit();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
